// File: rtl/std_dffr_pipe_pkg.sv
// -----------------------------------------------------------------------------
// std_dffr_pipe_pkg
//   Shared sizing helpers for the std_dffr_pipe register pipeline.
//   pipe_cap(stages)   : number of entries the pipe can hold
//   pipe_occ_w(stages) : width of the occupancy counter, $clog2(cap+1)
//   STAGE_CNT_W        : width of the per-stage entry count
// Configuration macro: STD_DFFR_PIPE_SKID_EN (each stage holds two entries
// when defined, one otherwise).
// -----------------------------------------------------------------------------
package std_dffr_pipe_pkg;

    localparam int STAGE_CNT_W = 2;

`ifdef STD_DFFR_PIPE_SKID_EN
    localparam int ENTRIES_PER_STAGE = 2;
`else
    localparam int ENTRIES_PER_STAGE = 1;
`endif

    function automatic int pipe_cap(input int stages);
        return ENTRIES_PER_STAGE * stages;
    endfunction

    function automatic int pipe_occ_w(input int stages);
        return $clog2(pipe_cap(stages) + 1);
    endfunction

endpackage

// File: rtl/std_pipe_stage.sv
// -----------------------------------------------------------------------------
// std_pipe_stage
//   One valid/ready register slice of the std_dffr_pipe chain.
//   Ports:
//     clk, resetn        clock, asynchronous active-low reset
//     flush_i            synchronous drop of every entry held by the slice
//     up_valid_i/up_ready_o/up_data_i   upstream handshake
//     dn_valid_o/dn_ready_i/dn_data_o   downstream handshake
//     cnt_o              number of entries currently held (0..2)
// Configuration macro: STD_DFFR_PIPE_SKID_EN
//   undefined : single main register, up_ready_o = ~valid | dn_ready_i
//   defined   : main + skid register, up_ready_o = ~skid_valid (registered)
// -----------------------------------------------------------------------------
module std_pipe_stage
    import std_dffr_pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush_i,
    input  logic                   up_valid_i,
    output logic                   up_ready_o,
    input  logic [DATA_WIDTH-1:0]  up_data_i,
    output logic                   dn_valid_o,
    input  logic                   dn_ready_i,
    output logic [DATA_WIDTH-1:0]  dn_data_o,
    output logic [STAGE_CNT_W-1:0] cnt_o
);

    logic                  v_q, v_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic                  up_xfer;

`ifdef STD_DFFR_PIPE_SKID_EN
    logic                  sv_q, sv_d;
    logic [DATA_WIDTH-1:0] sd_q, sd_d;
    logic                  main_free;

    // Ready is a pure register output, which breaks the combinational
    // out_ready -> in_ready chain across stages.
    assign up_ready_o = ~sv_q;
    assign up_xfer    = up_valid_i & ~sv_q & ~flush_i;
    assign main_free  = ~v_q | dn_ready_i;

    always_comb begin
        v_d  = v_q;
        d_d  = d_q;
        sv_d = sv_q;
        sd_d = sd_q;
        if (flush_i) begin
            v_d  = 1'b0;
            sv_d = 1'b0;
        end else if (main_free) begin
            if (sv_q) begin
                // The skid entry is older than anything upstream, so it
                // refills main first. up_xfer is 0 here because ready = ~sv_q.
                v_d  = 1'b1;
                d_d  = sd_q;
                sv_d = 1'b0;
            end else begin
                v_d = up_xfer;
                if (up_xfer) begin
                    d_d = up_data_i;
                end
            end
        end else if (up_xfer) begin
            // Main is stalled: park the incoming entry in the skid register.
            sv_d = 1'b1;
            sd_d = up_data_i;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sv_q <= 1'b0;
            sd_q <= RESET_VALUE;
        end else begin
            sv_q <= sv_d;
            sd_q <= sd_d;
        end
    end

    assign cnt_o = STAGE_CNT_W'(v_q) + STAGE_CNT_W'(sv_q);
`else
    // An empty slice always accepts, so bubbles collapse under a stall.
    assign up_ready_o = ~v_q | dn_ready_i;
    assign up_xfer    = up_valid_i & up_ready_o & ~flush_i;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush_i) begin
            v_d = 1'b0;
        end else if (up_ready_o) begin
            v_d = up_valid_i;
        end
        if (up_xfer) begin
            d_d = up_data_i;
        end
    end

    assign cnt_o = STAGE_CNT_W'(v_q);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_q <= 1'b0;
            d_q <= RESET_VALUE;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign dn_valid_o = v_q;
    assign dn_data_o  = d_q;

endmodule

// File: rtl/std_dffr_pipe.sv
// -----------------------------------------------------------------------------
// std_dffr_pipe
//   Parametrised multi-stage register pipeline with valid/ready flow control,
//   bubble collapsing, synchronous flush and asynchronous active-low reset.
//   Ports:
//     clk        clock, all state on posedge
//     resetn     asynchronous active-low reset
//     flush      drop all stored entries at the next edge
//     in_valid / in_ready / in_data     upstream handshake
//     out_valid / out_ready / out_data  downstream handshake
//     occupancy  number of valid entries held
//   Parameters: DATA_WIDTH, STAGES (forward latency), RESET_VALUE.
// Configuration macro: STD_DFFR_PIPE_SKID_EN (2-entry skid slices, no
// combinational out_ready -> in_ready path, capacity 2*STAGES).
// -----------------------------------------------------------------------------
module std_dffr_pipe
    import std_dffr_pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    STAGES      = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    localparam int                   OCC_W       = pipe_occ_w(STAGES)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [OCC_W-1:0]      occupancy
);

    // Link i feeds stage i; link STAGES is the pipe output.
    logic                   vld_c [0:STAGES];
    logic                   rdy_c [0:STAGES];
    logic [DATA_WIDTH-1:0]  dat_c [0:STAGES];
    logic [STAGE_CNT_W-1:0] cnt_c [0:STAGES-1];
    logic [OCC_W-1:0]       occ_sum;

    // Flush masks both external handshakes so nothing transfers that cycle.
    assign vld_c[0]      = in_valid & ~flush;
    assign dat_c[0]      = in_data;
    assign rdy_c[STAGES] = out_ready & ~flush;
    assign in_ready      = rdy_c[0] & ~flush;
    assign out_valid     = vld_c[STAGES] & ~flush;
    assign out_data      = dat_c[STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        std_pipe_stage #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk        (clk),
            .resetn     (resetn),
            .flush_i    (flush),
            .up_valid_i (vld_c[i]),
            .up_ready_o (rdy_c[i]),
            .up_data_i  (dat_c[i]),
            .dn_valid_o (vld_c[i+1]),
            .dn_ready_i (rdy_c[i+1]),
            .dn_data_o  (dat_c[i+1]),
            .cnt_o      (cnt_c[i])
        );
    end

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_sum = occ_sum + OCC_W'(cnt_c[i]);
        end
    end

    assign occupancy = occ_sum;

endmodule
